// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores on a req/ack data port with wait states,
// aligns load data, resolves branches and stalls upstream while an access is open.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [1:0]  crt_wb_in,
  input  logic [2:0]  crt_mem_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] pc_in,
  input  logic        zero_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] dato_b_in,
  input  logic [4:0]  rd_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [1:0]  crt_wb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_target_out,
  output logic        fault_out
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] cnt;
  logic [1:0]      cap_wb;
  logic [31:0]     cap_alu;
  logic [4:0]      cap_rd;
  logic [2:0]      cap_f3;
  logic            cap_st;

  logic        mem_op, is_st, f3_ok, misal, bad, go, timeout_hit, br_now;
  logic [1:0]  sz;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, lane, ld;

  assign sz     = funct3_in[1:0];
  assign mem_op = valid_in & (crt_mem_in[1] | crt_mem_in[0]);
  assign is_st  = crt_mem_in[0];
  assign br_now = valid_in & crt_mem_in[2] & zero_in;

  always_comb begin
    if (is_st) f3_ok = ~funct3_in[2] & (sz != 2'b11);
    else       f3_ok = (sz != 2'b11) & ~(funct3_in[2] & (sz == 2'b10));
    misal = ((sz == 2'b01) & alu_result_in[0]) |
            ((sz == 2'b10) & (alu_result_in[1:0] != 2'b00));
  end

  assign bad = mem_op & (~f3_ok | misal);
  assign go  = mem_op & ~bad;

  always_comb begin
    case (sz)
      2'b00: begin
        be_n    = 4'b0001 << alu_result_in[1:0];
        wdata_n = {4{dato_b_in[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << {alu_result_in[1], 1'b0};
        wdata_n = {2{dato_b_in[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = dato_b_in;
      end
    endcase
  end

  // Lane extraction uses the offset/size captured at accept time.
  always_comb begin
    lane = dmem_rdata >> {cap_alu[1:0], 3'b000};
    case (cap_f3[1:0])
      2'b00:   ld = {{24{~cap_f3[2] & lane[7]}}, lane[7:0]};
      2'b01:   ld = {{16{~cap_f3[2] & lane[15]}}, lane[15:0]};
      default: ld = lane;
    endcase
  end

  assign timeout_hit = (state == BUSY) & ~dmem_ack & (ACK_TIMEOUT != 0) & (cnt == TO_LAST);

  // Gated by reset so upstream is released the moment reset lands mid-access.
  assign stall_out = rst & (((state == IDLE) & go) |
                            ((state == BUSY) & ~dmem_ack & ~timeout_hit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      cnt               <= '0;
      cap_wb            <= '0;
      cap_alu           <= '0;
      cap_rd            <= '0;
      cap_f3            <= '0;
      cap_st            <= 1'b0;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_be           <= '0;
      dmem_wdata        <= '0;
      valid_out         <= 1'b0;
      crt_wb_out        <= '0;
      read_data_out     <= '0;
      alu_result_out    <= '0;
      rd_out            <= '0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
      fault_out         <= 1'b0;
    end else begin
      valid_out        <= 1'b0;
      fault_out        <= 1'b0;
      branch_taken_out <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state      <= BUSY;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= is_st;
            dmem_addr  <= {alu_result_in[31:2], 2'b00};
            dmem_be    <= be_n;
            dmem_wdata <= wdata_n;
            cap_wb     <= crt_wb_in;
            cap_alu    <= alu_result_in;
            cap_rd     <= rd_in;
            cap_f3     <= funct3_in;
            cap_st     <= is_st;
          end else begin
            valid_out         <= valid_in;
            crt_wb_out        <= bad ? 2'b00 : crt_wb_in;
            fault_out         <= bad;
            read_data_out     <= '0;
            alu_result_out    <= alu_result_in;
            rd_out            <= rd_in;
            branch_taken_out  <= br_now;
            branch_target_out <= pc_in;
          end
        end
        BUSY: begin
          if (dmem_ack || timeout_hit) begin
            // Upstream is held through this cycle, so live branch inputs still belong to this op.
            state             <= IDLE;
            dmem_req          <= 1'b0;
            valid_out         <= 1'b1;
            crt_wb_out        <= dmem_ack ? cap_wb : 2'b00;
            fault_out         <= ~dmem_ack;
            read_data_out     <= (dmem_ack & ~cap_st) ? ld : 32'd0;
            alu_result_out    <= cap_alu;
            rd_out            <= cap_rd;
            branch_taken_out  <= br_now;
            branch_target_out <= pc_in;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, randomized ops checked against
// a transaction-level model, plus a mid-access reset sequence.
module tb_mem_access_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [1:0]  crt_wb_in;
  logic [2:0]  crt_mem_in;
  logic [2:0]  funct3_in;
  logic [31:0] pc_in;
  logic        zero_in;
  logic [31:0] alu_result_in;
  logic [31:0] dato_b_in;
  logic [4:0]  rd_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic [1:0]  crt_wb_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  rd_out;
  logic        branch_taken_out;
  logic [31:0] branch_target_out;
  logic        fault_out;

  mem_access_stage #(.ACK_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .crt_wb_in(crt_wb_in),
    .crt_mem_in(crt_mem_in), .funct3_in(funct3_in), .pc_in(pc_in), .zero_in(zero_in),
    .alu_result_in(alu_result_in), .dato_b_in(dato_b_in), .rd_in(rd_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .valid_out(valid_out), .crt_wb_out(crt_wb_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .rd_out(rd_out), .branch_taken_out(branch_taken_out),
    .branch_target_out(branch_target_out), .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [1:0] wb; logic [2:0] mem; logic [2:0] f3; logic [31:0] pc; logic z;
    logic [31:0] alu; logic [31:0] b; logic [4:0] rd; int d; logic [31:0] rdata;
    int e_req; logic e_we; logic [3:0] e_be; logic [31:0] e_wdata;
    logic e_valid; logic [1:0] e_wb; logic [31:0] e_rdo; logic e_fault; logic e_br;
  } vec_t;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Transaction-level reference: what one instruction must produce, from the ISA rules.
  function automatic vec_t model(input vec_t x);
    vec_t y;
    bit memop, st, legal, tout;
    int nbytes, off;
    longint unsigned val;
    y = x;
    memop  = x.v && (x.mem[1] || x.mem[0]);
    st     = x.mem[0];
    off    = int'(x.alu[1:0]);
    nbytes = 1 << x.f3[1:0];
    legal  = (st ? (x.f3 inside {3'd0, 3'd1, 3'd2}) : (x.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
             && (off % nbytes == 0);
    y.e_br = x.v && x.mem[2] && x.z;
    y.e_req = 0; y.e_we = 0; y.e_be = 0; y.e_wdata = 0; y.e_rdo = 0; y.e_fault = 0;
    y.e_valid = x.v; y.e_wb = x.wb;
    if (memop && !legal) begin
      y.e_valid = 1; y.e_wb = 0; y.e_fault = 1;
    end else if (memop) begin
      tout    = x.d >= TO;
      y.e_req = tout ? TO : x.d + 1;
      y.e_we  = st;
      y.e_be  = 4'(((1 << nbytes) - 1) << off);
      if (st) y.e_wdata = (nbytes == 1) ? x.b[7:0] * 32'h01010101 :
                          (nbytes == 2) ? x.b[15:0] * 32'h00010001 : x.b;
      y.e_valid = 1; y.e_wb = tout ? 2'b00 : x.wb; y.e_fault = tout;
      if (!st && !tout) begin
        val = 64'(x.rdata >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 1);
        if (!x.f3[2] && val >= (64'd1 << (8 * nbytes - 1))) val = val - (64'd1 << (8 * nbytes));
        y.e_rdo = val[31:0];
      end
    end
    return y;
  endfunction

  task automatic drive(input vec_t x);
    valid_in = x.v; crt_wb_in = x.wb; crt_mem_in = x.mem; funct3_in = x.f3; pc_in = x.pc;
    zero_in = x.z; alu_result_in = x.alu; dato_b_in = x.b; rd_in = x.rd; dmem_rdata = x.rdata;
  endtask

  // Called at posedge+1; returns at posedge+1 after the retire edge has been checked.
  task automatic run_vec(input vec_t x, input int idx);
    int cyc, reqc, stalls;
    drive(x); dmem_ack = 0;
    #1; stalls = stall_out ? 1 : 0; reqc = 0; cyc = 0;
    while (stall_out === 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (dmem_req) begin
        reqc++;
        chk($sformatf("v%0d_addr", idx), dmem_addr, {x.alu[31:2], 2'b00});
        chk($sformatf("v%0d_we", idx), 32'(dmem_we), 32'(x.e_we));
        chk($sformatf("v%0d_be", idx), 32'(dmem_be), 32'(x.e_be));
        if (x.e_we) chk($sformatf("v%0d_wdata", idx), dmem_wdata, x.e_wdata);
        dmem_ack = (reqc - 1 == x.d);
      end else dmem_ack = 0;
      #1; if (stall_out) stalls++;
    end
    if (cyc >= 20) chk($sformatf("v%0d_stall_bound", idx), cyc, 0);
    @(posedge clk); #1; dmem_ack = 0;
    chk($sformatf("v%0d_stalls", idx), stalls, x.e_req);
    chk($sformatf("v%0d_reqcycles", idx), reqc, x.e_req);
    chk($sformatf("v%0d_req_off", idx), 32'(dmem_req), 0);
    chk($sformatf("v%0d_valid", idx), 32'(valid_out), 32'(x.e_valid));
    chk($sformatf("v%0d_wb", idx), 32'(crt_wb_out), 32'(x.e_wb));
    chk($sformatf("v%0d_fault", idx), 32'(fault_out), 32'(x.e_fault));
    chk($sformatf("v%0d_rdata", idx), read_data_out, x.e_rdo);
    chk($sformatf("v%0d_alu", idx), alu_result_out, x.alu);
    chk($sformatf("v%0d_rd", idx), 32'(rd_out), 32'(x.rd));
    chk($sformatf("v%0d_br", idx), 32'(branch_taken_out), 32'(x.e_br));
    chk($sformatf("v%0d_target", idx), branch_target_out, x.pc);
  endtask

  vec_t tbl[14];
  vec_t x;

  initial begin
    tbl[0]  = '{v:1, wb:2'b10, alu:32'h1234, rd:5, pc:32'h40, e_valid:1, e_wb:2'b10, default:0};
    tbl[1]  = '{v:1, mem:3'b100, z:1, pc:32'h88, alu:32'h7, rd:1, e_valid:1, e_br:1, default:0};
    tbl[2]  = '{v:1, wb:2'b11, mem:3'b010, f3:3'b000, alu:32'h103, rd:7, d:2, rdata:32'h80FFFFFF,
                pc:32'h100, e_req:3, e_be:4'b1000, e_valid:1, e_wb:2'b11, e_rdo:32'hFFFFFF80, default:0};
    tbl[3]  = '{v:1, wb:2'b11, mem:3'b010, f3:3'b100, alu:32'h103, rd:7, d:2, rdata:32'h80FFFFFF,
                pc:32'h104, e_req:3, e_be:4'b1000, e_valid:1, e_wb:2'b11, e_rdo:32'h00000080, default:0};
    tbl[4]  = '{v:1, mem:3'b001, f3:3'b001, alu:32'h202, b:32'hAAAABEEF, d:0, e_req:1, e_we:1,
                e_be:4'b1100, e_wdata:32'hBEEFBEEF, e_valid:1, default:0};
    tbl[5]  = '{v:1, wb:2'b11, mem:3'b010, f3:3'b010, alu:32'h5, rd:9, e_valid:1, e_fault:1, default:0};
    tbl[6]  = '{v:1, mem:3'b001, f3:3'b010, alu:32'h300, b:32'h12345678, d:99, e_req:4, e_we:1,
                e_be:4'b1111, e_wdata:32'h12345678, e_valid:1, e_fault:1, default:0};
    tbl[7]  = '{v:1, wb:2'b11, mem:3'b010, f3:3'b010, alu:32'h10, rd:3, d:1, rdata:32'hCAFEF00D,
                e_req:2, e_be:4'hF, e_valid:1, e_wb:2'b11, e_rdo:32'hCAFEF00D, default:0};
    tbl[8]  = '{v:1, wb:2'b11, mem:3'b010, f3:3'b011, alu:32'h20, rd:4, e_valid:1, e_fault:1, default:0};
    tbl[9]  = '{v:1, wb:2'b01, mem:3'b011, f3:3'b000, alu:32'h1, b:32'h1234565A, d:0, e_req:1, e_we:1,
                e_be:4'b0010, e_wdata:32'h5A5A5A5A, e_valid:1, e_wb:2'b01, default:0};
    tbl[10] = '{v:1, wb:2'b11, mem:3'b010, f3:3'b001, alu:32'h2, rd:6, d:1, rdata:32'h80011234,
                e_req:2, e_be:4'b1100, e_valid:1, e_wb:2'b11, e_rdo:32'hFFFF8001, default:0};
    tbl[11] = '{v:1, mem:3'b001, f3:3'b100, alu:32'h0, b:32'h55, e_valid:1, e_fault:1, default:0};
    tbl[12] = '{v:0, wb:2'b11, mem:3'b010, f3:3'b010, alu:32'h44, rd:2, e_valid:0, e_wb:2'b11, default:0};
    tbl[13] = '{v:1, wb:2'b11, mem:3'b010, f3:3'b101, alu:32'h3, rd:8, e_valid:1, e_fault:1, default:0};

    rst = 1'b0; dmem_ack = 1'b0;
    drive('{default:0});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", 32'(dmem_be), 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_wb", 32'(crt_wb_out), 0);
    chk("rst_rdata", read_data_out, 0);
    chk("rst_alu", alu_result_out, 0);
    chk("rst_rd", 32'(rd_out), 0);
    chk("rst_br", 32'(branch_taken_out), 0);
    chk("rst_target", branch_target_out, 0);
    chk("rst_fault", 32'(fault_out), 0);
    chk("rst_stall", 32'(stall_out), 0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

    for (int i = 0; i < 60; i++) begin
      x = '{default:0};
      x.v = ($urandom_range(0, 7) != 0);
      x.wb = 2'($urandom_range(0, 3)); x.mem = 3'($urandom_range(0, 7));
      x.f3 = 3'($urandom_range(0, 7)); x.pc = $urandom; x.z = 1'($urandom_range(0, 1));
      x.alu = $urandom; x.b = $urandom; x.rd = 5'($urandom_range(0, 31));
      x.d = $urandom_range(0, 5); x.rdata = $urandom;
      if ($urandom_range(0, 1) != 0) x.alu[1:0] = 2'b00;
      run_vec(model(x), 100 + i);
    end

    // Reset landing mid-access, then a stale ack after release.
    drive('{v:1, wb:2'b11, mem:3'b010, f3:3'b010, alu:32'h40, default:0});
    @(posedge clk); #1;
    chk("mid_req_before", 32'(dmem_req), 1);
    #1; rst = 1'b0;
    #1;
    chk("mid_req", 32'(dmem_req), 0);
    chk("mid_valid", 32'(valid_out), 0);
    chk("mid_stall", 32'(stall_out), 0);
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; dmem_ack = 1'b1;
    @(posedge clk); #1;
    chk("stale_req", 32'(dmem_req), 0);
    chk("stale_valid", 32'(valid_out), 0);
    chk("stale_fault", 32'(fault_out), 0);
    dmem_ack = 1'b0;
    run_vec(tbl[7], 200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage, directly downstream of the EXE/MEM register. It consumes that register's control, ALU result, store data, PC, zero flag and rd.
- Runs loads and stores on a req/ack data-memory port with wait states.
- Aligns and sign-extends load data, resolves branches, and stalls upstream while an access is outstanding.
- Outputs are registered and feed the MEM/WB register.

Parameters:
ACK_TIMEOUT, 255, cycles BUSY waits for dmem_ack before aborting; 0 disables timeout.
TO_W, 8, width of timeout counter; ACK_TIMEOUT must fit in TO_W bits.

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
valid_in  in  1  EXE/MEM holds a live instruction
crt_wb_in  in  2  [1]=reg_write, [0]=mem_to_reg
crt_mem_in  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
funct3_in  in  3  access size/sign
pc_in  in  32  branch target
zero_in  in  1  ALU zero
alu_result_in  in  32  byte address / ALU value
dato_b_in  in  32  store data
rd_in  in  5  destination register
stall_out  out  1  hold EXE/MEM and earlier stages
dmem_req  out  1  bus request
dmem_we  out  1  1=write
dmem_addr  out  32  word address, {alu_result[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  access complete
dmem_rdata  in  32  read word, valid with ack
valid_out  out  1  MEM/WB payload valid
crt_wb_out  out  2  writeback control
read_data_out  out  32  extended load data
alu_result_out  out  32  passthrough
rd_out  out  5  passthrough
branch_taken_out  out  1  branch & zero
branch_target_out  out  32  pc_in
fault_out  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, valid_out, crt_wb_out, read_data_out, alu_result_out, rd_out, branch_taken_out, branch_target_out, fault_out. Timeout counter 0.
- Reset mid-access drops dmem_req immediately. An ack arriving later is ignored.
- Memory op = valid_in & (mem_read | mem_write). Write wins if both bits are set.
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3: 000, 001, 010. Any other funct3 is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Non-memory op, or valid_in=0: 1-cycle latency. The next edge registers valid_out=valid_in and all passthroughs. stall_out=0.
- Branch: branch_taken_out <= valid_in & branch & zero_in; branch_target_out <= pc_in. Both are registered with the other outputs.
- Faulting memory op (misaligned or illegal funct3), in IDLE:
  - no bus request;
  - next edge: valid_out=1, crt_wb_out=0 (writeback killed), fault_out=1 for one cycle;
  - stall_out=0.
- Legal memory op, FSM IDLE -> BUSY:
  - At the accepting edge, register dmem_req=1, we, addr, be and wdata. These stay stable until ack.
  - Capture crt_wb/rd/alu_result/funct3/addr[1:0] internally.
  - Counter cleared.
- BUSY on dmem_ack=1:
  - drop dmem_req next edge and return to IDLE;
  - register valid_out=1, crt_wb_out=captured, alu_result_out, rd_out;
  - loads: read_data_out = extracted lane. LB/LH sign-extend, LBU/LHU zero-extend.
- BUSY with no ack: counter increments each cycle. When counter==ACK_TIMEOUT-1 without ack (ACK_TIMEOUT!=0):
  - drop req and go to IDLE;
  - valid_out=1, crt_wb_out=0, fault_out=1.
- Outside access-completion edges, valid_out pulses for one cycle per retired instruction. Otherwise valid_out=0.
- stall_out (combinational) = (IDLE & legal memory op) | (BUSY & ~dmem_ack & ~timeout_hit). It drops in the ack cycle so EXE/MEM advances exactly once.
  - Op presented at cycle T, ack at cycle A: stall_out high T..A-1, dmem_req high T+1..A, valid_out at A+1.
  - Minimum memory-op occupancy: 2 cycles (ack at T+1).
- Store lanes:
  - SB: wdata={4{b[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{b[15:0]}}, be=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=b, be=4'b1111.
- Loads drive be per the same size rule with we=0.
- read_data_out is 0 for non-load retires.

Test Plan:
- rst=0 during BUSY with req high -> req, valid_out, stall_out all 0 immediately; stale dmem_ack after release of rst ignored; IDLE.
- Non-memory op, crt_wb=2'b10, alu=0x1234, rd=5 -> next cycle valid_out=1, alu_result_out=0x1234, rd_out=5, stall_out never 1.
- LB addr=0x103, dmem_rdata=0x80FF_FF_FF, ack 3 cycles after req -> be=1000, stall 3 cycles, read_data_out=0xFFFFFF80. Repeat LBU -> 0x00000080.
- SH addr=0x202, b=0xAAAA_BEEF, ack at T+1 -> addr=0x200, be=1100, wdata=0xBEEFBEEF, we=1; stall exactly 1 cycle; valid_out at T+2.
- LW addr=0x5 -> no req, fault_out=1, crt_wb_out=0, valid_out=1 next cycle; no stall.
- ACK_TIMEOUT=4, SW never acked -> req high 4 cycles, then req=0, fault_out=1, crt_wb_out=0, stall released; following op proceeds normally.
